// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - message/state types, byte-class constants and data-length helper for the MIDI parser
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    PITCH    = 3'd6
  } msg_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX
  } parse_state_t;

  localparam logic [7:0] STATUS_SYSEX = 8'hF0;
  localparam logic [7:0] STATUS_EOX   = 8'hF7;
  localparam logic [7:0] RT_BASE      = 8'hF8;

  // Program change and channel aftertouch carry one data byte; all other channel messages carry two.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    return (status inside {[8'hC0:8'hDF]}) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// rtl/midi_byte_classify.sv - combinational MIDI byte classifier
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0] din,
  output logic       is_data,
  output logic       is_chan_status,
  output logic       is_sysex,
  output logic       is_eox,
  output logic       is_syscommon,
  output logic       is_realtime
);

  assign is_data        = ~din[7];
  assign is_chan_status = din inside {[8'h80:8'hEF]};
  assign is_sysex       = (din == STATUS_SYSEX);
  assign is_eox         = (din == STATUS_EOX);
  assign is_syscommon   = din inside {[8'hF1:8'hF6]};
  assign is_realtime    = (din >= RT_BASE);

endmodule

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI channel-voice parser with running status; MIDI_REALTIME_EN adds rt_valid/rt_byte
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter bit         OMNI        = 1'b1,
  parameter logic [3:0] LISTEN_CH   = 4'd0,
  parameter bit         VEL0_IS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       msg_valid,
  output logic [2:0] msg_type,
  output logic [3:0] msg_chan,
  output logic [6:0] data1,
  output logic [6:0] data2,
  output logic [7:0] stray_cnt
`ifdef MIDI_REALTIME_EN
  ,
  output logic       rt_valid,
  output logic [7:0] rt_byte
`endif
);

  logic is_data, is_chan_status, is_sysex, is_eox, is_syscommon, is_realtime;

  midi_byte_classify u_classify (
    .din            (byte_in),
    .is_data        (is_data),
    .is_chan_status (is_chan_status),
    .is_sysex       (is_sysex),
    .is_eox         (is_eox),
    .is_syscommon   (is_syscommon),
    .is_realtime    (is_realtime)
  );

  parse_state_t state;
  logic [7:0]   run_status;
  logic [6:0]   d1;

  logic         msg_done;
  logic         chan_ok;
  msg_type_t    done_type;
  logic [6:0]   done_d1;
  logic [6:0]   done_d2;

  // Candidate message formed by the current byte; only committed when msg_done is set.
  always_comb begin
    done_d1   = d1;
    done_d2   = byte_in[6:0];
    done_type = msg_type_t'(run_status[6:4]);
    if (state == ST_WAIT_D1) begin
      done_d1 = byte_in[6:0];
      done_d2 = 7'd0;
    end
    if (VEL0_IS_OFF && done_type == NOTE_ON && done_d2 == 7'd0) begin
      done_type = NOTE_OFF;
    end
    msg_done = byte_valid && is_data &&
               ((state == ST_WAIT_D2) ||
                (state == ST_WAIT_D1 && data_len(run_status) == 2'd1));
  end

  assign chan_ok = OMNI || (run_status[3:0] == LISTEN_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      run_status <= 8'd0;
      d1         <= 7'd0;
      msg_valid  <= 1'b0;
      msg_type   <= 3'd0;
      msg_chan   <= 4'd0;
      data1      <= 7'd0;
      data2      <= 7'd0;
      stray_cnt  <= 8'd0;
`ifdef MIDI_REALTIME_EN
      rt_valid   <= 1'b0;
      rt_byte    <= 8'd0;
`endif
    end else begin
      msg_valid <= 1'b0;
`ifdef MIDI_REALTIME_EN
      rt_valid  <= 1'b0;
`endif
      if (byte_valid) begin
        if (is_realtime) begin
`ifdef MIDI_REALTIME_EN
          rt_valid <= 1'b1;
          rt_byte  <= byte_in;
`endif
        end else if (is_chan_status) begin
          run_status <= byte_in;
          state      <= ST_WAIT_D1;
        end else if (is_sysex) begin
          run_status <= 8'd0;
          state      <= ST_SYSEX;
        end else if (is_syscommon || is_eox) begin
          run_status <= 8'd0;
          state      <= ST_IDLE;
        end else if (is_data) begin
          unique case (state)
            ST_IDLE: begin
              if (stray_cnt != 8'hFF) stray_cnt <= stray_cnt + 8'd1;
            end
            ST_WAIT_D1: begin
              d1 <= byte_in[6:0];
              if (data_len(run_status) == 2'd2) state <= ST_WAIT_D2;
            end
            ST_WAIT_D2: state <= ST_WAIT_D1;
            default: ;
          endcase
        end
      end
      // Filtered-out channels still advance the parser but leave the held outputs alone.
      if (msg_done && chan_ok) begin
        msg_valid <= 1'b1;
        msg_type  <= done_type;
        msg_chan  <= run_status[3:0];
        data1     <= done_d1;
        data2     <= done_d2;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - scoreboard bench for midi_msg_parser (omni and channel-3 instances)
module tb_midi_msg_parser;

  typedef struct {
    int         cyc;
    logic [2:0] t;
    logic [3:0] c;
    logic [6:0] d1;
    logic [6:0] d2;
  } exp_msg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'd0;

  logic       mv_a, mv_b;
  logic [2:0] mt_a, mt_b;
  logic [3:0] mc_a, mc_b;
  logic [6:0] d1_a, d1_b, d2_a, d2_b;
  logic [7:0] sc_a, sc_b;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  exp_msg_t q_a[$];
  exp_msg_t q_b[$];

  int         m_stray;
  bit         m_have_rs;
  bit         m_sysex;
  logic [7:0] m_rs;
  logic [6:0] m_pend[$];

`ifdef MIDI_REALTIME_EN
  logic       rt_a, rt_b;
  logic [7:0] rtb_a, rtb_b;
  int         q_rt_c[$];
  logic [7:0] q_rt_b[$];
`endif

  midi_msg_parser u_omni (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(mv_a), .msg_type(mt_a), .msg_chan(mc_a),
    .data1(d1_a), .data2(d2_a), .stray_cnt(sc_a)
`ifdef MIDI_REALTIME_EN
    , .rt_valid(rt_a), .rt_byte(rtb_a)
`endif
  );

  midi_msg_parser #(.OMNI(1'b0), .LISTEN_CH(4'd3)) u_ch3 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(mv_b), .msg_type(mt_b), .msg_chan(mc_b),
    .data1(d1_b), .data2(d2_b), .stray_cnt(sc_b)
`ifdef MIDI_REALTIME_EN
    , .rt_valid(rt_b), .rt_byte(rtb_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int c, input logic [2:0] t, input logic [3:0] ch,
                                       input logic [6:0] a, input logic [6:0] b);
    return {32'(c), 11'd0, t, ch, a, b};
  endfunction

  // Reference: running status byte plus a list of collected data bytes.
  task automatic model_byte(input logic [7:0] b);
    exp_msg_t e;
    int need;
    int code;
    if (b >= 8'hF8) begin
`ifdef MIDI_REALTIME_EN
      q_rt_c.push_back(cyc + 1);
      q_rt_b.push_back(b);
`endif
      return;
    end
    if (b >= 8'h80 && b <= 8'hEF) begin
      m_have_rs = 1; m_rs = b; m_sysex = 0; m_pend.delete();
    end else if (b == 8'hF0) begin
      m_have_rs = 0; m_sysex = 1; m_pend.delete();
    end else if (b >= 8'hF1) begin
      m_have_rs = 0; m_sysex = 0; m_pend.delete();
    end else if (m_sysex) begin
    end else if (!m_have_rs) begin
      if (m_stray < 255) m_stray++;
    end else begin
      m_pend.push_back(b[6:0]);
      need = (m_rs >= 8'hC0 && m_rs <= 8'hDF) ? 1 : 2;
      if (m_pend.size() == need) begin
        code  = int'(m_rs) / 16 - 8;
        e.cyc = cyc + 1;
        e.t   = code[2:0];
        e.c   = m_rs[3:0];
        e.d1  = m_pend[0];
        e.d2  = (need == 2) ? m_pend[1] : 7'd0;
        if (e.t == 3'd1 && e.d2 == 7'd0) e.t = 3'd0;
        q_a.push_back(e);
        if (e.c == 4'd3) q_b.push_back(e);
        m_pend.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_stray = 0; m_have_rs = 0; m_sysex = 0; m_rs = 8'd0; m_pend.delete();
    check("rst_msg_valid_a", 64'(mv_a), 64'd0);
    check("rst_msg_valid_b", 64'(mv_b), 64'd0);
    check("rst_fields_a", pack(0, mt_a, mc_a, d1_a, d2_a), 64'd0);
    check("rst_fields_b", pack(0, mt_b, mc_b, d1_b, d2_b), 64'd0);
    check("rst_stray_a", 64'(sc_a), 64'd0);
    check("rst_stray_b", 64'(sc_b), 64'd0);
`ifdef MIDI_REALTIME_EN
    check("rst_rt", {55'd0, rt_a, rtb_a}, 64'd0);
`endif
  endtask

  task automatic phase_end(input string nm);
    idle(3);
    check({nm, "_drain_a"}, 64'(q_a.size()), 64'd0);
    check({nm, "_drain_b"}, 64'(q_b.size()), 64'd0);
    check({nm, "_stray_a"}, 64'(sc_a), 64'(m_stray));
    check({nm, "_stray_b"}, 64'(sc_b), 64'(m_stray));
`ifdef MIDI_REALTIME_EN
    check({nm, "_drain_rt"}, 64'(q_rt_c.size()), 64'd0);
`endif
    q_a.delete();
    q_b.delete();
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 60)      return 8'($urandom_range(0, 127));
    else if (r < 80) return 8'($urandom_range(128, 239));
    else if (r < 85) return 8'hF0;
    else if (r < 90) return 8'hF7;
    else if (r < 95) return 8'($urandom_range(241, 246));
    else             return 8'($urandom_range(248, 255));
  endfunction

  always @(negedge clk) begin : mon_a
    exp_msg_t e;
    if (mv_a) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL msg_a_unexpected: got type %0d chan %0d d1 0x%0h d2 0x%0h, none required", mt_a, mc_a, d1_a, d2_a);
      end else begin
        e = q_a.pop_front();
        check("msg_a cyc/type/chan/d1/d2", pack(cyc, mt_a, mc_a, d1_a, d2_a), pack(e.cyc, e.t, e.c, e.d1, e.d2));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_msg_t e;
    if (mv_b) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL msg_b_unexpected: got type %0d chan %0d d1 0x%0h d2 0x%0h, none required", mt_b, mc_b, d1_b, d2_b);
      end else begin
        e = q_b.pop_front();
        check("msg_b cyc/type/chan/d1/d2", pack(cyc, mt_b, mc_b, d1_b, d2_b), pack(e.cyc, e.t, e.c, e.d1, e.d2));
      end
    end
  end

`ifdef MIDI_REALTIME_EN
  always @(negedge clk) begin : mon_rt
    int c;
    logic [7:0] b;
    if (rt_a) begin
      if (q_rt_c.size() == 0) begin
        tests++; fails++;
        $display("FAIL rt_unexpected: got rt_byte 0x%0h, none required", rtb_a);
      end else begin
        c = q_rt_c.pop_front();
        b = q_rt_b.pop_front();
        check("rt cyc/byte", {32'(cyc), 24'd0, rtb_a}, {32'(c), 24'd0, b});
      end
    end
  end
`endif

  initial begin
    reset_dut();

    send(8'h90); send(8'h3C); send(8'h64);
    phase_end("note_on");

    send(8'h92); send(8'h40); send(8'h50); send(8'h40); send(8'h00);
    phase_end("running_status");

    send(8'hC5); send(8'h07); send(8'h09);
    phase_end("prog");

    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    phase_end("realtime");

    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h45);
    phase_end("sysex");

    send(8'h91); send(8'h3C); send(8'h64); send(8'h93); send(8'h3C); send(8'h64);
    phase_end("chan_filter");

    send(8'hE3); send(8'h11); idle(1); send(8'h22); send(8'hB3); send(8'h07); send(8'hF2); send(8'h05);
    phase_end("pitch_syscommon");

    send(8'h90);
    reset_dut();
    send(8'h3C); send(8'h64);
    phase_end("mid_reset");

    reset_dut();
    for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 127)));
    phase_end("stray_sat");

    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    phase_end("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
